noc_leaf_router_node: RTL
=========================

Name: noc_leaf_router_node

Overview:
Parametrised successor to the fixed 4-spine GPU node router. It connects one local NI port to NUM_SPINES spine links. Every input has a FIFO, every output is a registered stage with valid/ready backpressure, and each output has its own round-robin arbiter, so the node no longer relies on an always-ready router. The destination is taken from the flit header, so there are no separate dest_addr ports. Flits arriving on a spine that are not addressed to this node are dropped and counted.

Parameters:
- DWIDTH, 16: flit width; must be >= 6.
- NUM_SPINES, 4: number of spine ports; power of two, 1..8.
- FIFO_DEPTH, 4: entries per input FIFO; power of two, >= 2.
- GROUP_ID, 4'b0101: this node's group, compared with dest[5:2].
- NODE_ID, 2'd0: this node's index within the group, compared with dest[1:0].

Ports:
- ACLK, in, 1: clock.
- ARESETn, in, 1: synchronous active-low reset.
- local_in_data, in, DWIDTH: flit from the NI.
- local_in_valid, in, 1: local_in_data is valid.
- local_in_ready, out, 1: node can accept a local flit.
- local_out_data, out, DWIDTH: flit to the NI.
- local_out_valid, out, 1: local_out_data is valid.
- local_out_ready, in, 1: NI can accept.
- spine_in_data, in, NUM_SPINES*DWIDTH: packed spine inputs; spine i occupies [i*DWIDTH +: DWIDTH].
- spine_in_valid, in, NUM_SPINES: per-spine valid.
- spine_in_ready, out, NUM_SPINES: per-spine ready.
- spine_out_data, out, NUM_SPINES*DWIDTH: packed spine outputs.
- spine_out_valid, out, NUM_SPINES: per-spine valid.
- spine_out_ready, in, NUM_SPINES: per-spine ready.
- in_fifo_full, out, NUM_SPINES+1: FIFO full flags; bit 0 is local, bit i+1 is spine i.
- drop_count, out, 16: saturating count of misrouted spine flits.
- busy, out, 1: any FIFO non-empty or any output valid.

Behaviour:
- Clock and reset: single clock ACLK. ARESETn is synchronous and active-low.
- Reset values: all FIFOs empty; all *_out_valid = 0; *_out_data = 0; drop_count = 0; all arbiter pointers = 0; busy = 0; in_fifo_full = 0.
- Reset mid-operation: all in-flight flits are discarded with no partial outputs. Ready outputs are 0 while ARESETn = 0.
- Header decode: dest = flit[DWIDTH-1 -: 6]. A flit is local when dest[5:2] == GROUP_ID and dest[1:0] == NODE_ID. Otherwise the target spine is dest[5:2] mod NUM_SPINES.
- Routing rules:
  - Local-input flits: a local dest goes to the local output (loopback); any other dest goes to the selected spine.
  - Spine-input flits: a local dest goes to the local output; any other dest is popped and dropped, and drop_count increments (saturates at 16'hFFFF).
- Input handshake: *_in_ready = !fifo_full, independent of valid. A push occurs when valid && ready. A push while full is impossible because ready is low.
- FIFO: registered storage; the head is visible the cycle after it is written. Simultaneous push and pop are allowed at any occupancy below full. At full, a pop frees a slot that becomes visible as ready in the next cycle. Pointers wrap modulo FIFO_DEPTH and carry an extra wrap bit for the full/empty test.
- Arbitration:
  - Each output has a round-robin arbiter over the NUM_SPINES+1 inputs whose FIFO head targets that output.
  - The pointer advances to grant+1 after each grant and holds when there is no grant.
  - A single input head can win at most one output per cycle, and it is popped only on grant.
- Output stage: each output is a one-entry register. It loads when (!out_valid || out_ready) and a grant exists. out_valid and out_data stay stable while out_valid && !out_ready (AXI-stream rule).
- Throughput and latency:
  - With no contention and ready held high, throughput is 1 flit/cycle per output.
  - Input handshake in cycle k gives out_valid in cycle k+2.
- Drops: a drop takes one cycle, needs no output grant, and occurs even when the outputs are stalled.

Decomposition:
- Shared package noc_pkg:
  - DEST_W = 6 and the GROUP/NODE field offsets.
  - Function dest_of(flit) returning the 6-bit destination.
  - Function is_local(dest, group, node).
  - Port-index constants with LOCAL_PORT = 0.
- Sub-module noc_sync_fifo (DWIDTH, DEPTH), instantiated NUM_SPINES+1 times.
- The arbiters are generated inline in a for-generate, one per output.

Test Plan:
1. Reset with GROUP_ID=4'b0101, NODE_ID=0: drive local_in 16'h3001 with valid for one cycle → spine_out[3] = 16'h3001 two cycles later (dest 0x0C, 3 mod 4 = 3); all other outputs stay invalid; drop_count = 0.
2. Spine 1 sends 16'h50AA (dest 0x14, this node) → local_out_data = 16'h50AA in cycle k+2. Spine 2 sends 16'h3055 (dest 0x0C, not this node) → dropped; drop_count = 1; no output asserts.
3. Spines 0..3 each send one flit to 16'h5000|i in the same cycle, with local_out_ready = 1 → local_out delivers the flits in order i = 0, 1, 2, 3 on consecutive cycles. A second burst is granted starting after the last grantee (rotation check).
4. Hold spine_out_ready[3] = 0 and stream 6 flits of 16'h3000+n from local → out register holds 16'h3000 stable; FIFO fills 4 entries; local_in_ready drops; in_fifo_full[0] = 1. Release ready → all flits delivered in order with no loss or duplication.
5. Drive 16'h5012 from local (loopback) and 16'h5034 from spine 0 in the same cycle → both delivered on local_out on consecutive cycles, local-port flit first after reset.
6. Assert ARESETn = 0 with 3 flits queued and an output valid → next cycle all valids = 0, FIFOs empty, busy = 0. After release, traffic resumes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the leaf router node: header layout, port numbering
// and the destination decode helpers.
package noc_pkg;

  localparam int DEST_W     = 6;
  localparam int GROUP_LSB  = 2;
  localparam int GROUP_W    = 4;
  localparam int NODE_LSB   = 0;
  localparam int NODE_W     = 2;
  localparam int LOCAL_PORT = 0;
  localparam int SPINE_BASE = 1;
  localparam int MAX_FLIT_W = 256;

  // Flits are zero-extended to MAX_FLIT_W so one helper serves any DWIDTH.
  function automatic logic [DEST_W-1:0] dest_of(input logic [MAX_FLIT_W-1:0] flit,
                                                input int dwidth);
    return flit[dwidth-1 -: DEST_W];
  endfunction

  function automatic logic is_local(input logic [DEST_W-1:0]  dest,
                                    input logic [GROUP_W-1:0] group,
                                    input logic [NODE_W-1:0]  node);
    return (dest[GROUP_LSB +: GROUP_W] == group) && (dest[NODE_LSB +: NODE_W] == node);
  endfunction

  function automatic int wrap_inc(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Registered-storage synchronous FIFO with wrap-bit pointers; head is read
// combinationally from storage, so it appears the cycle after the write.
module noc_sync_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wptr, r_rptr;
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic              w_do_push, w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/noc_leaf_router_node.sv
// Leaf router node: one local NI port plus NUM_SPINES spine links, input FIFOs,
// per-output round-robin arbiters and registered valid/ready output stages.
module noc_leaf_router_node
  import noc_pkg::*;
#(
  parameter int         DWIDTH     = 16,
  parameter int         NUM_SPINES = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] GROUP_ID   = 4'b0101,
  parameter logic [1:0] NODE_ID    = 2'd0
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [DWIDTH-1:0]            local_in_data,
  input  logic                         local_in_valid,
  output logic                         local_in_ready,
  output logic [DWIDTH-1:0]            local_out_data,
  output logic                         local_out_valid,
  input  logic                         local_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [NUM_SPINES:0]          in_fifo_full,
  output logic [15:0]                  drop_count,
  output logic                         busy
);

  localparam int NP = NUM_SPINES + 1;
  localparam int PW = $clog2(NP);

  logic [NP-1:0][DWIDTH-1:0] w_in_data, w_head, w_od;
  logic [NP-1:0]             w_in_valid, w_in_ready, w_push, w_pop;
  logic [NP-1:0]             w_empty, w_full, w_req, w_drop, w_oready, w_ov;
  logic [NP-1:0][PW-1:0]     w_tgt;
  logic [NP-1:0][NP-1:0]     w_gnt;  // [output][input]
  logic [15:0]               r_drop_cnt;
  logic [16:0]               w_drop_sum;

  assign w_in_data[LOCAL_PORT]  = local_in_data;
  assign w_in_valid[LOCAL_PORT] = local_in_valid;
  assign w_oready[LOCAL_PORT]   = local_out_ready;
  assign local_out_data         = w_od[LOCAL_PORT];
  assign local_out_valid        = w_ov[LOCAL_PORT];

  for (genvar s = 0; s < NUM_SPINES; s++) begin : g_spine_map
    assign w_in_data[SPINE_BASE+s]             = spine_in_data[s*DWIDTH +: DWIDTH];
    assign w_in_valid[SPINE_BASE+s]            = spine_in_valid[s];
    assign w_oready[SPINE_BASE+s]              = spine_out_ready[s];
    assign spine_out_data[s*DWIDTH +: DWIDTH]  = w_od[SPINE_BASE+s];
    assign spine_out_valid[s]                  = w_ov[SPINE_BASE+s];
  end

  // Ready is forced low during reset so nothing is accepted into a FIFO being cleared.
  assign w_in_ready     = {NP{ARESETn}} & ~w_full;
  assign w_push         = w_in_valid & w_in_ready;
  assign local_in_ready = w_in_ready[LOCAL_PORT];
  assign spine_in_ready = w_in_ready[NP-1:SPINE_BASE];
  assign in_fifo_full   = w_full;
  assign busy           = (|(~w_empty)) | (|w_ov);
  assign drop_count     = r_drop_cnt;

  for (genvar j = 0; j < NP; j++) begin : g_in
    logic [DEST_W-1:0] w_dest;
    logic              w_loc;

    noc_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (ACLK),
      .i_rst_n (ARESETn),
      .i_push  (w_push[j]),
      .i_wdata (w_in_data[j]),
      .i_pop   (w_pop[j]),
      .o_rdata (w_head[j]),
      .o_empty (w_empty[j]),
      .o_full  (w_full[j])
    );

    assign w_dest = dest_of(MAX_FLIT_W'(w_head[j]), DWIDTH);
    assign w_loc  = is_local(w_dest, GROUP_ID, NODE_ID);

    if (j == LOCAL_PORT) begin : g_local
      assign w_tgt[j]  = w_loc ? PW'(LOCAL_PORT)
                               : PW'(SPINE_BASE + (int'(w_dest[GROUP_LSB +: GROUP_W]) % NUM_SPINES));
      assign w_req[j]  = !w_empty[j];
      assign w_drop[j] = 1'b0;
    end else begin : g_spine
      // Spine traffic only ever terminates here; anything else is discarded.
      assign w_tgt[j]  = PW'(LOCAL_PORT);
      assign w_req[j]  = !w_empty[j] && w_loc;
      assign w_drop[j] = !w_empty[j] && !w_loc;
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    logic [NP-1:0]     w_reqv;
    logic              w_any, w_load;
    logic [PW-1:0]     w_sel, r_ptr;
    logic              r_ov;
    logic [DWIDTH-1:0] r_od;

    for (genvar j = 0; j < NP; j++) begin : g_req
      assign w_reqv[j]   = w_req[j] && (w_tgt[j] == PW'(o));
      assign w_gnt[o][j] = w_load && (w_sel == PW'(j));
    end

    // Scan downwards so the requester closest to r_ptr is the last one written.
    always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int k = NP - 1; k >= 0; k--) begin
        if (w_reqv[wrap_inc(int'(r_ptr), k, NP)]) begin
          w_any = 1'b1;
          w_sel = PW'(wrap_inc(int'(r_ptr), k, NP));
        end
      end
    end

    assign w_load = w_any && (!r_ov || w_oready[o]);

    always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
        r_ptr <= '0;
        r_ov  <= 1'b0;
        r_od  <= '0;
      end else if (w_load) begin
        r_ptr <= PW'(wrap_inc(int'(w_sel), 1, NP));
        r_ov  <= 1'b1;
        r_od  <= w_head[w_sel];
      end else if (w_oready[o]) begin
        r_ov  <= 1'b0;
      end
    end

    assign w_ov[o] = r_ov;
    assign w_od[o] = r_od;
  end

  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < NP; o++) begin
      w_pop = w_pop | w_gnt[o];
    end
  end

  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int j = 0; j < NP; j++) begin
      w_drop_sum = w_drop_sum + 17'(w_drop[j]);
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn)           r_drop_cnt <= '0;
    else if (w_drop_sum[16]) r_drop_cnt <= 16'hFFFF;
    else                     r_drop_cnt <= w_drop_sum[15:0];
  end

endmodule
